// File: rtl/ethpipe_tx_sched_if.sv
// ethpipe_tx_sched_if
//  Bundles the TX scheduler's request, grant, beat and status signals.
//  master : scheduler side (drives grant/beat/done/abort/err_to)
//  slave  : descriptor queues + shared read channel side
//  enable      queue -> sched  stop issuing new grants when low
//  req         queue -> sched  per-port frame pending (level)
//  req_len     queue -> sched  per-port byte length, [i*LEN_W +: LEN_W]
//  grant       sched -> queue  one-hot owner, 0 when idle
//  beat_valid  sched -> read   beat request
//  beat_ready  read  -> sched  beat accepted
//  beat_last   sched -> read   final beat of frame
//  done        sched -> queue  1-cycle per-port completion pulse
//  abort       sched -> queue  1-cycle timeout abort pulse
//  err_to      sched -> queue  sticky timeout flag
//  err_clr     queue -> sched  clears err_to
interface ethpipe_tx_sched_if #(
  parameter int NPORT = 4,
  parameter int LEN_W = 11
);
  logic                   enable;
  logic [NPORT-1:0]       req;
  logic [NPORT*LEN_W-1:0] req_len;
  logic [NPORT-1:0]       grant;
  logic                   beat_valid;
  logic                   beat_ready;
  logic                   beat_last;
  logic [NPORT-1:0]       done;
  logic                   abort;
  logic                   err_to;
  logic                   err_clr;

  modport master (
    input  enable, req, req_len, beat_ready, err_clr,
    output grant, beat_valid, beat_last, done, abort, err_to
  );

  modport slave (
    output enable, req, req_len, beat_ready, err_clr,
    input  grant, beat_valid, beat_last, done, abort, err_to
  );
endinterface

// File: rtl/ethpipe_tx_sched.sv
// ethpipe_tx_sched
//  Round-robin scheduler sharing one TX frame-buffer read channel among
//  NPORT MAC TX queues. Grants one port at a time, sequences the frame as
//  64-bit beats, inserts IFG_CYC idle cycles after every frame or abort,
//  and aborts a frame whose consumer stalls for TIMEOUT cycles.
//  Ports:
//   sys_clk  clock, rising edge
//   sys_rst  asynchronous active-high reset
//   tx       ethpipe_tx_sched_if.master (req/len in, grant/beat/status out)
//  Build option:
//   ETHPIPE_TX_SCHED_STRICT_PRI_EN  fixed priority (lowest index wins),
//   no rotating pointer. Undefined: round-robin.
module ethpipe_tx_sched #(
  parameter int NPORT   = 4,
  parameter int LEN_W   = 11,
  parameter int IFG_CYC = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  ethpipe_tx_sched_if.master  tx
);

  localparam int BW = LEN_W - 2;                          // beat count, max 256
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int GW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [NPORT-1:0] done_q,  done_d;
  logic [BW-1:0]    rem_q,   rem_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic             abort_q, abort_d;
  logic             err_q,   err_d;
`ifndef ETHPIPE_TX_SCHED_STRICT_PRI_EN
  logic [PW-1:0]    ptr_q,   ptr_d;
`endif

  // Arbiter and beat-count computation for the candidate winner
  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic [LEN_W-1:0] len_sel;
  logic [LEN_W:0]   len_eff;
  logic [LEN_W:0]   len_rnd;
  logic [BW-1:0]    beats;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
`ifdef ETHPIPE_TX_SCHED_STRICT_PRI_EN
    for (int unsigned i = 0; i < NPORT; i++) begin
      idx = PW'(i);
      if (!found && tx.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`else
    for (int unsigned i = 0; i < NPORT; i++) begin
      idx = PW'((32'(ptr_q) + i) % NPORT);
      if (!found && tx.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`endif
    len_sel = tx.req_len[win*LEN_W +: LEN_W];
    len_eff = (len_sel < LEN_W'(64)) ? (LEN_W+1)'(64) : {1'b0, len_sel};
    len_rnd = len_eff + (LEN_W+1)'(7);
    beats   = len_rnd[LEN_W:3];
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rem_q   <= '0;
      stall_q <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
`ifndef ETHPIPE_TX_SCHED_STRICT_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`ifndef ETHPIPE_TX_SCHED_STRICT_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    rem_d   = rem_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    abort_d = 1'b0;
    err_d   = err_q & ~tx.err_clr;
`ifndef ETHPIPE_TX_SCHED_STRICT_PRI_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx.enable && found) begin
          state_d = S_XFER;
          grant_d = NPORT'(1) << win;
          rem_d   = beats;
          stall_d = '0;
`ifndef ETHPIPE_TX_SCHED_STRICT_PRI_EN
          ptr_d   = (win == PW'(NPORT - 1)) ? '0 : PW'(win + 1'b1);
`endif
        end
      end
      S_XFER: begin
        // beat_valid is high throughout XFER, so beat_ready alone means accepted
        if (tx.beat_ready) begin
          stall_d = '0;
          if (rem_q == BW'(1)) begin
            done_d  = grant_q;
            grant_d = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end else if (stall_q == SW'(TIMEOUT - 1)) begin
          // this stalled cycle is the TIMEOUT-th in a row; set beats clear
          abort_d = 1'b1;
          err_d   = 1'b1;
          grant_d = '0;
          stall_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IFG_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx.grant      = grant_q;
    tx.beat_valid = (state_q == S_XFER);
    tx.beat_last  = (state_q == S_XFER) && (rem_q == BW'(1));
    tx.done       = done_q;
    tx.abort      = abort_q;
    tx.err_to     = err_q;
  end

endmodule

// File: tb/tb_ethpipe_tx_sched.sv
module tb_ethpipe_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ethpipe_tx_sched_if #(.NPORT(4), .LEN_W(11)) tx ();

  ethpipe_tx_sched #(
    .NPORT(4), .LEN_W(11), .IFG_CYC(2), .TIMEOUT(1023)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .tx(tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_vals);
    rst = 1'b1;
    tx.req = '0; tx.req_len = '0; tx.enable = 1'b0;
    tx.beat_ready = 1'b1; tx.err_clr = 1'b0;
    tick(); tick();
    if (check_vals) begin
      chk("rst_grant", 32'(tx.grant), 0);
      chk("rst_valid", 32'(tx.beat_valid), 0);
      chk("rst_last",  32'(tx.beat_last), 0);
      chk("rst_done",  32'(tx.done), 0);
      chk("rst_abort", 32'(tx.abort), 0);
      chk("rst_err",   32'(tx.err_to), 0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (tx.grant == 0 && waited < 2000) begin
      tick();
      waited++;
    end
    if (tx.grant == 0) chk("grant_timeout", 0, 1);
  endtask

  // Runs a granted frame to completion with beat_ready=1 and checks its shape.
  task automatic xfer(input int port, input int exp_beats, input int en_off_at);
    int beats = 0;
    int last_at = 0;
    bit fin = 0;
    bit hold_ok = 1;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (tx.grant != 4'(1 << port)) hold_ok = 0;
      if (tx.beat_valid && tx.beat_ready) begin
        beats++;
        if (tx.beat_last) begin
          last_at = beats;
          fin = 1;
        end
      end
      if (en_off_at != 0 && beats >= en_off_at) tx.enable = 1'b0;
      tick();
    end
    chk("beats",      32'(beats), 32'(exp_beats));
    chk("last_at",    32'(last_at), 32'(exp_beats));
    chk("grant_hold", 32'(hold_ok), 1);
    chk("done",       32'(tx.done), 32'(1 << port));
    chk("grant_drop", 32'(tx.grant), 0);
    chk("valid_drop", 32'(tx.beat_valid), 0);
  endtask

  initial begin
    int w;
    int n;
    int beats;
    bit saw_done;

    // 1: all four request, len 64 -> rotation 0,1,2,3,0
    do_reset(1);
    tx.req = 4'b1111; tx.req_len = {4{11'd64}}; tx.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(w);
      chk("rr_grant", 32'(tx.grant), 32'(1 << (k % 4)));
      if (k == 4) tx.req = '0;
      xfer(k % 4, 8, 0);
    end
    tick();
    chk("done_pulse", 32'(tx.done), 0);

    // 2: port 2 len 100 -> 13 beats, regrant IFG_CYC+1 after done
    do_reset(0);
    tx.req = 4'b0100; tx.req_len = '0; tx.req_len[2*11 +: 11] = 11'd100; tx.enable = 1'b1;
    wait_grant(w);
    chk("p2_grant", 32'(tx.grant), 32'h4);
    xfer(2, 13, 0);
    wait_grant(w);
    chk("ifg_gap", 32'(w), 3);
    tx.req = '0;
    xfer(2, 13, 0);

    // 3: port 1 length extremes
    do_reset(0);
    tx.req = 4'b0010; tx.req_len = '0; tx.enable = 1'b1;
    wait_grant(w);
    chk("p1_grant", 32'(tx.grant), 32'h2);
    tx.req_len[1*11 +: 11] = 11'd2047;   // sampled only at the next grant
    xfer(1, 8, 0);
    wait_grant(w);
    tx.req = '0;
    xfer(1, 256, 0);

    // 4: port 3 stalls -> abort after 1023 cycles
    do_reset(0);
    tx.req = 4'b1000; tx.req_len = {4{11'd64}}; tx.enable = 1'b1;
    wait_grant(w);
    chk("p3_grant", 32'(tx.grant), 32'h8);
    tx.req = '0; tx.beat_ready = 1'b0;
    n = 0; saw_done = 0;
    while (!tx.abort && n < 1100) begin
      tick();
      n++;
      if (tx.done != 0) saw_done = 1;
    end
    chk("abort_cyc",   32'(n), 1023);
    chk("abort_grant", 32'(tx.grant), 0);
    chk("abort_valid", 32'(tx.beat_valid), 0);
    chk("err_set",     32'(tx.err_to), 1);
    chk("no_done",     32'(saw_done), 0);
    tx.beat_ready = 1'b1;
    tick();
    chk("abort_pulse", 32'(tx.abort), 0);
    chk("err_sticky",  32'(tx.err_to), 1);
    tx.err_clr = 1'b1;
    tick();
    tx.err_clr = 1'b0;
    chk("err_clr", 32'(tx.err_to), 0);

    // 5: enable dropped mid-frame; pending port 1 waits for enable
    do_reset(0);
    tx.req = 4'b0011; tx.req_len = {4{11'd64}}; tx.enable = 1'b1;
    wait_grant(w);
    chk("en_grant0", 32'(tx.grant), 32'h1);
    tx.req = 4'b0010;
    xfer(0, 8, 3);
    repeat (10) tick();
    chk("en_hold", 32'(tx.grant), 0);
    tx.enable = 1'b1;
    wait_grant(w);
    chk("en_grant1", 32'(tx.grant), 32'h2);
    chk("en_lat",    32'(w), 1);
    tx.req = '0;
    xfer(1, 8, 0);

    // 6: reset mid-frame, rr pointer must restart at 0
    do_reset(0);
    tx.req = 4'b0110; tx.req_len = {4{11'd64}}; tx.enable = 1'b1;
    wait_grant(w);
    chk("mr_grant", 32'(tx.grant), 32'h2);
    beats = 0;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      if (tx.beat_valid && tx.beat_ready) beats++;
      if (beats < 5) tick();
    end
    rst = 1'b1;
    #1;
    chk("mr_grant0", 32'(tx.grant), 0);
    chk("mr_valid0", 32'(tx.beat_valid), 0);
    chk("mr_done0",  32'(tx.done), 0);
    chk("mr_err0",   32'(tx.err_to), 0);
    tick();
    rst = 1'b0;
    wait_grant(w);
    chk("mr_regrant", 32'(tx.grant), 32'h2);
    tx.req = '0;
    xfer(1, 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
